// File: rtl/input_conditioner.sv
// Pad-to-core input conditioner.
// The raw button and X switches are synchronised into clk. The button is
// debounced and produces one-cycle press/release events. On each accepted
// press the synchronised X value is captured into a valid/ready output
// register for the core.
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,      // 2..4
  parameter int DEBOUNCE_CYCLES = 50000,  // >= 2
  parameter int X_W             = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           button_i,
  input  logic [X_W-1:0] x_i,
  output logic [X_W-1:0] x_sync_o,
  output logic           level_o,
  output logic           press_o,
  output logic           release_o,
  output logic [X_W-1:0] data_o,
  output logic           valid_o,
  input  logic           ready_i,
  output logic           overrun_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    DB_LOW,
    DB_WAIT_HIGH,
    DB_HIGH,
    DB_WAIT_LOW
  } db_state_t;

  logic [SYNC_STAGES-1:0] b_sync;
  logic [X_W-1:0]         x_sync [SYNC_STAGES];
  logic                   b_s;
  db_state_t              db_state;
  logic [CNT_W-1:0]       db_cnt;
  logic                   transfer;

  assign b_s      = b_sync[SYNC_STAGES-1];
  assign x_sync_o = x_sync[SYNC_STAGES-1];
  assign transfer = valid_o && ready_i;

  // Synchroniser chains: bit/stage 0 samples the pad, the last stage feeds the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) x_sync[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage take its neighbour's
      // old value, so the chain really is SYNC_STAGES flops deep.
      b_sync    <= {b_sync[SYNC_STAGES-2:0], button_i};
      x_sync[0] <= x_i;
      for (int i = 1; i < SYNC_STAGES; i++) x_sync[i] <= x_sync[i-1];
    end
  end

  // Debounce FSM: a level change is accepted after DEBOUNCE_CYCLES consecutive
  // samples at the new level; a single contrary sample restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_state  <= DB_LOW;
      db_cnt    <= '0;
      level_o   <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
    end else begin
      // NOTE: pulses default low here and are raised only on the accepting
      // edge, which keeps them exactly one cycle wide.
      press_o   <= 1'b0;
      release_o <= 1'b0;
      unique case (db_state)
        DB_LOW: begin
          if (b_s) begin
            db_state <= DB_WAIT_HIGH;
            db_cnt   <= CNT_W'(1);
          end
        end
        DB_WAIT_HIGH: begin
          if (!b_s) begin
            db_state <= DB_LOW;
            db_cnt   <= '0;
          end else if (db_cnt == CNT_LAST) begin
            db_state <= DB_HIGH;
            db_cnt   <= '0;
            level_o  <= 1'b1;
            press_o  <= 1'b1;
          end else begin
            db_cnt <= db_cnt + CNT_W'(1);
          end
        end
        DB_HIGH: begin
          if (!b_s) begin
            db_state <= DB_WAIT_LOW;
            db_cnt   <= CNT_W'(1);
          end
        end
        DB_WAIT_LOW: begin
          if (b_s) begin
            db_state <= DB_HIGH;
            db_cnt   <= '0;
          end else if (db_cnt == CNT_LAST) begin
            db_state  <= DB_LOW;
            db_cnt    <= '0;
            level_o   <= 1'b0;
            release_o <= 1'b1;
          end else begin
            db_cnt <= db_cnt + CNT_W'(1);
          end
        end
        default: begin
          db_state <= DB_LOW;
          db_cnt   <= '0;
        end
      endcase
    end
  end

  // Capture register: load X on press when empty or draining this cycle,
  // otherwise flag the lost press; a plain transfer just empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o    <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else if (press_o) begin
      if (!valid_o || transfer) begin
        data_o  <= x_sync_o;
        valid_o <= 1'b1;
      end else begin
        overrun_o <= 1'b1;
      end
    end else if (transfer) begin
      valid_o <= 1'b0;
    end
  end

endmodule
